ant_pheromone_agent: RTL and testbench

- Registered, parametrised ACO routing agent for one mesh router; sits between the input buffers and the route/VC allocation stage.
- Holds a per-node pheromone table (NODES rows × 4 mesh directions) and routes normal packets and forward ants along the best-pheromone minimal direction.
- Turns forward ants into backward ants at their destination and retraces backward ants through the ant hop memory.
- Reinforces pheromone on backward-ant arrival, evaporates the table periodically, and drops ants whose hop memory overflows.

---
 rtl/ant_pheromone_agent.sv | 257 +++++++++++++++++++++++++
 tb/tb_ant_pheromone_agent.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ant_pheromone_agent.sv
// ACO routing agent for one mesh router: pheromone-table lookup, ant hop memory
// handling, backward-ant reinforcement and periodic evaporation, one-cycle latency.
`ifndef N
`define N 5
`endif
`ifndef M
`define M 5
`endif
`ifndef X_NODES
`define X_NODES 4
`endif
`ifndef Y_NODES
`define Y_NODES 4
`endif
`ifndef NODES
`define NODES 16
`endif
`ifndef MEM_SIZE
`define MEM_SIZE 8
`endif

package ant_pkg;
  localparam int COORD_W = 2;
  localparam int NUM_W   = 4;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } hop_t;

  typedef struct packed {
    logic [COORD_W-1:0]       x_dest;
    logic [COORD_W-1:0]       y_dest;
    logic [COORD_W-1:0]       x_source;
    logic [COORD_W-1:0]       y_source;
    logic                     ant;
    logic                     backward;
    logic [NUM_W-1:0]         num_memory;
    hop_t [`MEM_SIZE-1:0]     memory;
    logic [15:0]              payload;
  } packet_t;
endpackage

module ant_pheromone_agent
  import ant_pkg::*;
#(
  parameter int X_LOC       = 0,
  parameter int Y_LOC       = 0,
  parameter int MEM_DEPTH   = 8,
  parameter int PH_W        = 8,
  parameter int PH_INIT     = 128,
  parameter int PH_MIN      = 1,
  parameter int PH_MAX      = 255,
  parameter int DELTA       = 16,
  parameter int EVAP_PERIOD = 1024
) (
  input  logic                          clk,
  input  logic                          reset,
  input  packet_t [0:`N-1]              i_data,
  input  logic [0:`N-1]                 i_data_val,
  output packet_t [0:`N-1]              o_data,
  output logic [0:`N-1]                 o_data_val,
  output logic [0:`N-1][`M-1:0]         o_output_req,
  output logic [0:`N-1]                 o_ant_drop,
  output logic                          o_update_drop,
  input  logic [$clog2(`NODES)-1:0]     i_dbg_node,
  output logic [3:0][PH_W-1:0]          o_dbg_pheromone
);

  localparam int NODE_W = $clog2(`NODES);
  localparam int CNT_W  = $clog2(EVAP_PERIOD);
  localparam logic [4:0] REQ_LOCAL = 5'b10000;
  localparam logic [4:0] REQ_PY    = 5'b01000;
  localparam logic [4:0] REQ_PX    = 5'b00100;
  localparam logic [4:0] REQ_NY    = 5'b00010;
  localparam logic [4:0] REQ_NX    = 5'b00001;
  localparam hop_t HERE = '{x: COORD_W'(X_LOC), y: COORD_W'(Y_LOC)};

  typedef logic [3:0][PH_W-1:0] row_t;

  row_t                table_reg [`NODES];
  logic [CNT_W-1:0]    evap_cnt_reg;
  logic                evap_tick;

  packet_t             pkt_next  [`N];
  logic [4:0]          req_next  [`N];
  logic                val_next  [`N];
  logic                drop_next [`N];
  logic                bwd_next  [`N];

  logic                upd_valid;
  logic [NODE_W-1:0]   upd_row;
  logic [1:0]          upd_dir;
  logic                upd_drop_next;
  row_t                upd_row_val;

  function automatic logic [NODE_W-1:0] node_of(logic [COORD_W-1:0] x, logic [COORD_W-1:0] y);
    return NODE_W'(int'(y) * `X_NODES + int'(x));
  endfunction

  // Dimension-ordered step: X is resolved before Y.
  function automatic logic [4:0] toward(hop_t t);
    if (t.x > HERE.x) return REQ_PX;
    if (t.x < HERE.x) return REQ_NX;
    if (t.y > HERE.y) return REQ_PY;
    if (t.y < HERE.y) return REQ_NY;
    return REQ_LOCAL;
  endfunction

  function automatic logic [PH_W-1:0] sat_inc(logic [PH_W-1:0] e);
    logic [PH_W:0] sum;
    sum = {1'b0, e} + (PH_W+1)'(DELTA);
    return (sum > (PH_W+1)'(PH_MAX)) ? PH_W'(PH_MAX) : sum[PH_W-1:0];
  endfunction

  function automatic logic [PH_W-1:0] sat_dec(logic [PH_W-1:0] e);
    return (e > PH_W'(PH_MIN)) ? e - PH_W'(1) : PH_W'(PH_MIN);
  endfunction

  function automatic row_t decay_row(row_t r);
    row_t o;
    for (int d = 0; d < 4; d++) o[d] = sat_dec(r[d]);
    return o;
  endfunction

  assign evap_tick       = (evap_cnt_reg == CNT_W'(EVAP_PERIOD - 1));
  assign o_dbg_pheromone = table_reg[i_dbg_node];

  for (genvar gi = 0; gi < `N; gi++) begin : g_port
    always_comb begin
      packet_t          pkt;
      row_t             dest_row;
      logic [3:0]       prod;
      logic [4:0]       best_req;
      logic [PH_W-1:0]  best_val;
      logic             found;
      logic             at_dest;
      hop_t             last;
      hop_t             prev;
      hop_t             tgt;

      pkt           = i_data[gi];
      pkt_next[gi]  = pkt;
      val_next[gi]  = i_data_val[gi];
      req_next[gi]  = '0;
      drop_next[gi] = 1'b0;
      bwd_next[gi]  = 1'b0;

      at_dest  = (pkt.x_dest == HERE.x) && (pkt.y_dest == HERE.y);
      dest_row = table_reg[node_of(pkt.x_dest, pkt.y_dest)];
      prod     = {pkt.y_dest > HERE.y, pkt.x_dest > HERE.x,
                  pkt.y_dest < HERE.y, pkt.x_dest < HERE.x};

      // Strict '>' keeps the lowest-index direction on ties.
      best_req = '0;
      best_val = '0;
      found    = 1'b0;
      for (int b = 0; b < 4; b++) begin
        if (prod[b] && (!found || dest_row[b] > best_val)) begin
          found    = 1'b1;
          best_val = dest_row[b];
          best_req = '0;
          best_req[b] = 1'b1;
        end
      end

      last = '0;
      tgt  = '{x: pkt.x_dest, y: pkt.y_dest};
      prev = tgt;
      for (int m = 0; m < `MEM_SIZE; m++) begin
        if (m + 1 == int'(pkt.num_memory)) last = pkt.memory[m];
        if (m < int'(pkt.num_memory) && pkt.memory[m] == HERE) tgt = prev;
        prev = pkt.memory[m];
      end

      if (!i_data_val[gi]) begin
        pkt_next[gi] = '0;
      end else if (!pkt.ant) begin
        req_next[gi] = at_dest ? REQ_LOCAL : best_req;
      end else if (!pkt.backward) begin
        if (at_dest) begin
          pkt_next[gi].backward = 1'b1;
          pkt_next[gi].x_source = pkt.x_dest;
          pkt_next[gi].y_source = pkt.y_dest;
          pkt_next[gi].x_dest   = pkt.x_source;
          pkt_next[gi].y_dest   = pkt.y_source;
          req_next[gi] = (pkt.num_memory == '0) ? REQ_LOCAL : toward(last);
        end else if (int'(pkt.num_memory) < MEM_DEPTH) begin
          for (int m = 0; m < `MEM_SIZE; m++)
            if (m == int'(pkt.num_memory)) pkt_next[gi].memory[m] = HERE;
          pkt_next[gi].num_memory = pkt.num_memory + NUM_W'(1);
          req_next[gi] = best_req;
        end else begin
          pkt_next[gi]  = '0;
          val_next[gi]  = 1'b0;
          drop_next[gi] = 1'b1;
        end
      end else begin
        bwd_next[gi] = (gi != 0);
        req_next[gi] = at_dest ? REQ_LOCAL : toward(tgt);
      end
    end
  end

  // Port p reinforces table column p mod 4 (port 4 arrives from -X).
  always_comb begin
    upd_valid     = 1'b0;
    upd_row       = '0;
    upd_dir       = '0;
    upd_drop_next = 1'b0;
    for (int p = 1; p < `N; p++) begin
      if (bwd_next[p]) begin
        if (!upd_valid) begin
          upd_valid = 1'b1;
          upd_row   = node_of(i_data[p].x_source, i_data[p].y_source);
          upd_dir   = 2'(p % 4);
        end else begin
          upd_drop_next = 1'b1;
        end
      end
    end
  end

  always_comb begin
    upd_row_val = table_reg[upd_row];
    for (int d = 0; d < 4; d++)
      upd_row_val[d] = (d == int'(upd_dir)) ? sat_inc(table_reg[upd_row][d])
                                            : sat_dec(table_reg[upd_row][d]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < `NODES; r++) table_reg[r] <= {4{PH_W'(PH_INIT)}};
      evap_cnt_reg  <= '0;
      o_data        <= '0;
      o_data_val    <= '0;
      o_output_req  <= '0;
      o_ant_drop    <= '0;
      o_update_drop <= 1'b0;
    end else begin
      evap_cnt_reg <= evap_tick ? '0 : evap_cnt_reg + CNT_W'(1);
      // A reinforced row takes only the reinforcement, even on an evaporation tick.
      for (int r = 0; r < `NODES; r++) begin
        if (upd_valid && NODE_W'(r) == upd_row) table_reg[r] <= upd_row_val;
        else if (evap_tick)                     table_reg[r] <= decay_row(table_reg[r]);
      end
      for (int p = 0; p < `N; p++) begin
        o_data[p]       <= pkt_next[p];
        o_data_val[p]   <= val_next[p];
        o_output_req[p] <= req_next[p];
        o_ant_drop[p]   <= drop_next[p];
      end
      o_update_drop <= upd_drop_next;
    end
  end

endmodule

// File: tb/tb_ant_pheromone_agent.sv
// Bench for ant_pheromone_agent: directed literal pins plus randomized traffic
// checked every cycle against a rule-level pheromone/routing model.
`ifndef N
`define N 5
`endif
`ifndef M
`define M 5
`endif
`ifndef NODES
`define NODES 16
`endif
`ifndef MEM_SIZE
`define MEM_SIZE 8
`endif

module tb_ant_pheromone_agent;
  import ant_pkg::*;

  localparam int XL = 1, YL = 1, MD = 8, EP = 64;

  logic                      clk = 1'b0;
  logic                      reset;
  packet_t [0:`N-1]          i_data;
  logic [0:`N-1]             i_data_val;
  packet_t [0:`N-1]          o_data;
  logic [0:`N-1]             o_data_val;
  logic [0:`N-1][`M-1:0]     o_output_req;
  logic [0:`N-1]             o_ant_drop;
  logic                      o_update_drop;
  logic [3:0]                i_dbg_node;
  logic [3:0][7:0]           o_dbg_pheromone;

  always #5 clk = ~clk;

  ant_pheromone_agent #(
    .X_LOC(XL), .Y_LOC(YL), .MEM_DEPTH(MD), .PH_W(8), .PH_INIT(128),
    .PH_MIN(1), .PH_MAX(255), .DELTA(16), .EVAP_PERIOD(EP)
  ) dut (
    .clk(clk), .reset(reset), .i_data(i_data), .i_data_val(i_data_val),
    .o_data(o_data), .o_data_val(o_data_val), .o_output_req(o_output_req),
    .o_ant_drop(o_ant_drop), .o_update_drop(o_update_drop),
    .i_dbg_node(i_dbg_node), .o_dbg_pheromone(o_dbg_pheromone)
  );

  int total = 0, bad = 0;
  int tbl [16][4];
  int ntbl[16][4];
  int cyc, ncyc, tnum = 0;
  packet_t    exp_data [`N];
  logic [4:0] exp_req  [`N];
  bit         exp_val  [`N];
  bit         exp_drop [`N];
  bit         exp_udrop;

  task automatic chk(string name, logic [127:0] act, logic [127:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, want);
    end
  endtask

  function automatic logic [4:0] toward_m(int tx, int ty);
    if (tx != XL) return (tx > XL) ? 5'b00100 : 5'b00001;
    if (ty != YL) return (ty > YL) ? 5'b01000 : 5'b00010;
    return 5'b10000;
  endfunction

  function automatic bit productive(int b, int xd, int yd);
    case (b)
      0: return xd < XL;
      1: return yd < YL;
      2: return xd > XL;
      default: return yd > YL;
    endcase
  endfunction

  function automatic logic [4:0] best_dir(int xd, int yd);
    int row = yd * 4 + xd;
    int best = -1;
    for (int b = 0; b < 4; b++)
      if (productive(b, xd, yd) && (best < 0 || tbl[row][b] > tbl[row][best])) best = b;
    return (best < 0) ? 5'b00000 : 5'(1 << best);
  endfunction

  function automatic void route(input packet_t pk, output packet_t o, output logic [4:0] rq,
                                output bit v, output bit d);
    int xd = int'(pk.x_dest);
    int yd = int'(pk.y_dest);
    int n  = int'(pk.num_memory);
    bit here_dest = (xd == XL) && (yd == YL);
    o = pk; rq = '0; v = 1'b1; d = 1'b0;
    if (!pk.ant) begin
      rq = here_dest ? 5'b10000 : best_dir(xd, yd);
    end else if (!pk.backward) begin
      if (here_dest) begin
        o.backward = 1'b1;
        o.x_source = pk.x_dest;  o.y_source = pk.y_dest;
        o.x_dest   = pk.x_source; o.y_dest  = pk.y_source;
        rq = (n == 0) ? 5'b10000 : toward_m(int'(pk.memory[n-1].x), int'(pk.memory[n-1].y));
      end else if (n < MD) begin
        o.memory[n]  = '{x: 2'(XL), y: 2'(YL)};
        o.num_memory = 4'(n + 1);
        rq = best_dir(xd, yd);
      end else begin
        o = '0; v = 1'b0; d = 1'b1;
      end
    end else if (here_dest) begin
      rq = 5'b10000;
    end else begin
      int m = -1;
      for (int k = n - 1; k >= 0; k--)
        if (int'(pk.memory[k].x) == XL && int'(pk.memory[k].y) == YL) begin m = k; break; end
      if (m > 0) rq = toward_m(int'(pk.memory[m-1].x), int'(pk.memory[m-1].y));
      else       rq = toward_m(xd, yd);
    end
  endfunction

  // Predict the effect of the current inputs, let one edge pass, then compare.
  task automatic cycle();
    packet_t o; logic [4:0] rq; bit v, d; int first; int row; int col;
    logic [31:0] want_row;
    bit any = 1'b0;
    if (reset) begin
      for (int p = 0; p < `N; p++) begin
        exp_data[p] = '0; exp_req[p] = '0; exp_val[p] = 0; exp_drop[p] = 0;
      end
      exp_udrop = 0;
      for (int r = 0; r < 16; r++) for (int c = 0; c < 4; c++) ntbl[r][c] = 128;
      ncyc = 0;
    end else begin
      ntbl = tbl;
      exp_udrop = 0;
      first = -1;
      for (int p = 0; p < `N; p++) begin
        if (i_data_val[p]) begin
          any = 1'b1;
          route(i_data[p], o, rq, v, d);
          exp_data[p] = o; exp_req[p] = rq; exp_val[p] = v; exp_drop[p] = d;
          if (p > 0 && i_data[p].ant && i_data[p].backward) begin
            if (first < 0) first = p; else exp_udrop = 1;
          end
        end else begin
          exp_data[p] = '0; exp_req[p] = '0; exp_val[p] = 0; exp_drop[p] = 0;
        end
      end
      if (cyc % EP == EP - 1)
        for (int r = 0; r < 16; r++) for (int c = 0; c < 4; c++)
          ntbl[r][c] = (tbl[r][c] - 1 < 1) ? 1 : tbl[r][c] - 1;
      if (first >= 0) begin
        row = int'(i_data[first].y_source) * 4 + int'(i_data[first].x_source);
        col = first % 4;
        for (int c = 0; c < 4; c++)
          if (c == col) ntbl[row][c] = (tbl[row][c] + 16 > 255) ? 255 : tbl[row][c] + 16;
          else          ntbl[row][c] = (tbl[row][c] - 1 < 1) ? 1 : tbl[row][c] - 1;
      end
      ncyc = cyc + 1;
    end
    if (any) begin
      tnum++;
      $display("txn %0d: reset=%0b val=%b", tnum, reset, i_data_val);
    end
    @(posedge clk); #1;
    tbl = ntbl;
    cyc = ncyc;
    for (int p = 0; p < `N; p++) begin
      chk($sformatf("val%0d", p), 128'(o_data_val[p]), 128'(exp_val[p]));
      chk($sformatf("req%0d", p), 128'(o_output_req[p]), 128'(exp_req[p]));
      chk($sformatf("drop%0d", p), 128'(o_ant_drop[p]), 128'(exp_drop[p]));
      if (exp_val[p]) chk($sformatf("data%0d", p), 128'(o_data[p]), 128'(exp_data[p]));
    end
    chk("update_drop", 128'(o_update_drop), 128'(exp_udrop));
    want_row = {8'(tbl[i_dbg_node][3]), 8'(tbl[i_dbg_node][2]),
                8'(tbl[i_dbg_node][1]), 8'(tbl[i_dbg_node][0])};
    chk("dbg_row", 128'(o_dbg_pheromone), 128'(want_row));
  endtask

  function automatic packet_t mk(int xs, int ys, int xd, int yd, bit a, bit bw, int n);
    packet_t pk = '0;
    pk.x_source = 2'(xs); pk.y_source = 2'(ys);
    pk.x_dest = 2'(xd);   pk.y_dest = 2'(yd);
    pk.ant = a; pk.backward = bw; pk.num_memory = 4'(n);
    pk.payload = 16'($urandom);
    return pk;
  endfunction

  function automatic packet_t rnd_pkt();
    packet_t pk = '0;
    int n;
    pk.x_source = 2'($urandom_range(0, 3)); pk.y_source = 2'($urandom_range(0, 3));
    if ($urandom_range(0, 3) == 0) begin pk.x_dest = 2'(XL); pk.y_dest = 2'(YL); end
    else begin pk.x_dest = 2'($urandom_range(0, 3)); pk.y_dest = 2'($urandom_range(0, 3)); end
    pk.ant = 1'($urandom_range(0, 1));
    pk.backward = pk.ant & 1'($urandom_range(0, 1));
    pk.payload = 16'($urandom);
    n = $urandom_range(0, MD);
    pk.num_memory = 4'(n);
    for (int k = 0; k < `MEM_SIZE; k++) begin
      if ($urandom_range(0, 2) == 0) pk.memory[k] = '{x: 2'(XL), y: 2'(YL)};
      else pk.memory[k] = '{x: 2'($urandom_range(0, 3)), y: 2'($urandom_range(0, 3))};
      if (k > 0 && pk.memory[k] == pk.memory[k-1]) pk.memory[k].x = pk.memory[k].x ^ 2'd1;
    end
    if (pk.ant && !pk.backward && n > 0 && int'(pk.memory[n-1].x) == XL && int'(pk.memory[n-1].y) == YL)
      pk.memory[n-1].x = 2'd0;
    return pk;
  endfunction

  task automatic idle();
    i_data = '0;
    i_data_val = '0;
  endtask

  initial begin
    packet_t pk;
    reset = 1'b1; i_dbg_node = '0; idle();
    cycle(); cycle();
    reset = 1'b0;
    for (int r = 0; r < 16; r++) begin
      i_dbg_node = 4'(r); #1;
      chk($sformatf("init_row%0d", r), 128'(o_dbg_pheromone), 128'({4{8'd128}}));
    end
    chk("init_outputs", 128'({o_data_val, o_output_req, o_ant_drop, o_update_drop}), 128'(0));

    pk = mk(0, 0, 1, 1, 0, 0, 0); i_data[2] = pk; i_data_val[2] = 1; cycle(); idle();
    chk("lit_local_req", 128'(o_output_req[2]), 128'(5'b10000));
    chk("lit_local_data", 128'(o_data[2]), 128'(pk));

    i_data[1] = mk(0, 0, 3, 3, 0, 0, 0); i_data_val[1] = 1; cycle(); idle();
    chk("lit_tie_px", 128'(o_output_req[1]), 128'(5'b00100));

    i_dbg_node = 4'd15;
    i_data[3] = mk(3, 3, 0, 0, 1, 1, 0); i_data_val[3] = 1; cycle(); idle();
    chk("lit_bwd_route", 128'(o_output_req[3]), 128'(5'b00001));
    chk("lit_row15", 128'(o_dbg_pheromone), 128'({8'd144, 8'd127, 8'd127, 8'd127}));

    i_data[1] = mk(0, 0, 3, 3, 0, 0, 0); i_data_val[1] = 1; cycle(); idle();
    chk("lit_pref_py", 128'(o_output_req[1]), 128'(5'b01000));

    pk = mk(0, 0, 3, 1, 1, 0, 2);
    pk.memory[0] = '{x: 2'd0, y: 2'd0}; pk.memory[1] = '{x: 2'd0, y: 2'd1};
    i_data[4] = pk; i_data_val[4] = 1; cycle(); idle();
    chk("lit_fwd_num", 128'(o_data[4].num_memory), 128'(4'd3));
    chk("lit_fwd_mem", 128'(o_data[4].memory[2]), 128'(4'b0101));

    i_data[1] = mk(0, 0, 3, 1, 1, 0, MD); i_data_val[1] = 1; cycle(); idle();
    chk("lit_full_val", 128'(o_data_val[1]), 128'(0));
    chk("lit_full_drop", 128'(o_ant_drop[1]), 128'(1));

    pk = mk(2, 3, 1, 1, 1, 0, 2); pk.memory[1] = '{x: 2'd0, y: 2'd1};
    i_data[2] = pk; i_data_val[2] = 1; cycle(); idle();
    chk("lit_turn_bwd", 128'(o_data[2].backward), 128'(1));
    chk("lit_turn_swap", 128'({o_data[2].x_source, o_data[2].y_source, o_data[2].x_dest, o_data[2].y_dest}),
        128'(8'b01_01_10_11));
    chk("lit_turn_req", 128'(o_output_req[2]), 128'(5'b00001));

    i_dbg_node = 4'd10;
    i_data[1] = mk(2, 2, 3, 3, 1, 1, 0); i_data[3] = mk(2, 2, 3, 3, 1, 1, 0);
    i_data_val[1] = 1; i_data_val[3] = 1; cycle(); idle();
    chk("lit_two_udrop", 128'(o_update_drop), 128'(1));
    chk("lit_two_val", 128'({o_data_val[1], o_data_val[3]}), 128'(2'b11));
    chk("lit_row10", 128'(o_dbg_pheromone), 128'({8'd127, 8'd127, 8'd144, 8'd127}));

    i_dbg_node = 4'd15;
    for (int k = 0; k < 7; k++) begin
      i_data[3] = mk(3, 3, 0, 0, 1, 1, 0); i_data_val[3] = 1; cycle(); idle();
    end
    chk("lit_saturate", 128'(o_dbg_pheromone), 128'({8'd255, 8'd120, 8'd120, 8'd120}));

    for (int t = 0; t < 2000; t++) begin
      reset = ($urandom_range(0, 99) == 0);
      i_dbg_node = 4'($urandom_range(0, 15));
      for (int p = 0; p < `N; p++) begin
        i_data[p] = rnd_pkt();
        i_data_val[p] = ($urandom_range(0, 2) != 0);
      end
      cycle();
    end

    reset = 1'b1; idle(); cycle(); reset = 1'b0;
    i_dbg_node = 4'd5;
    for (int k = 0; k < EP - 1; k++) cycle();
    chk("lit_evap_before", 128'(o_dbg_pheromone), 128'({4{8'd128}}));
    cycle();
    chk("lit_evap_first", 128'(o_dbg_pheromone), 128'({4{8'd127}}));
    for (int k = 0; k < EP * 128; k++) cycle();
    chk("lit_evap_floor", 128'(o_dbg_pheromone), 128'({4{8'd1}}));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
